scheduler_sched_info_fetch: RTL and testbench
=============================================

Name: scheduler_sched_info_fetch

Overview:
- Read-side consumer of the per-accelerator schedule-info memory (50-bit entries, one per accelerator, registered read with 1-cycle latency).
- Accepts fetch requests by accelerator id and issues the memory read.
- Tracks which entries hold unconsumed data by snooping the memory write port.
- Returns entry plus hit/miss on a valid/ready response channel; a successful fetch consumes the entry.

Parameters:
- MAX_ACCS, 16, number of accelerator entries; id width AW = $clog2(MAX_ACCS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  fetch request valid
- req_ready  out  1  block can accept a request
- req_acc_id  in  AW  accelerator id to fetch
- snoop_wr_en  in  1  copy of memory write-port enable
- snoop_wr_addr  in  AW  copy of memory write-port address
- snoop_wr_din  in  50  copy of memory write-port data
- mem_rd_en  out  1  memory read-port enable
- mem_rd_addr  out  AW  memory read-port address
- mem_rd_dout  in  50  memory read data, valid the cycle after mem_rd_en
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accepts response
- rsp_acc_id  out  AW  id of the response
- rsp_hit  out  1  1 = entry was pending, rsp_data meaningful
- rsp_data  out  50  entry contents; 0 on miss
- pending_mask  out  MAX_ACCS  bit i = entry i written and not yet consumed

Behaviour:
- Reset (async, any state, including mid-fetch):
  - FSM to IDLE; pending_mask = 0; rsp_valid = 0; rsp_hit = 0; rsp_data = 0; rsp_acc_id = 0; mem_rd_en = 0; mem_rd_addr = 0.
  - req_ready is 0 while rst is asserted.
- FSM states: IDLE, RD, RSP.
- IDLE:
  - req_ready = 1.
  - On req_valid (accept cycle T): latch id and hit = pending_mask[id].
  - If id < MAX_ACCS: mem_rd_en = 1 and mem_rd_addr = req_acc_id combinationally in T.
  - Clear pending_mask[id] at end of T if hit.
  - Go to RD.
- RD (T+1):
  - req_ready = 0.
  - rsp_data <= hit ? mem_rd_dout : 0; rsp_acc_id <= latched id; rsp_hit <= hit; rsp_valid <= 1.
  - Go to RSP.
- RSP (from T+2):
  - rsp_* held stable while rsp_valid = 1 and rsp_ready = 0.
  - On rsp_ready: rsp_valid <= 0, go to IDLE.
  - Next request can be accepted in the cycle after the handshake.
- Latency: request accepted at T gives rsp_valid at T+2. Minimum issue interval is 3 cycles.
- Snoop: every cycle snoop_wr_en with snoop_wr_addr < MAX_ACCS sets pending_mask[addr], in any state.
  - Write to an id that is already pending: bit stays 1 (overwrite, no error).
- Out-of-range id (req_acc_id >= MAX_ACCS, non-power-of-2 MAX_ACCS): no memory read; response has hit = 0, data = 0.
- Same-cycle snoop write and accept to the same id in T: behaviour selected by the optional feature. The memory is read-first, so mem_rd_dout returns old contents.
- Snoop write to the latched id in RD/RSP: sets the pending bit; the in-flight response is unaffected.

Optional Feature:
- SCHED_INFO_FETCH_BYPASS_EN
- Defined:
  - Same-cycle write/accept to the same id returns snoop_wr_din, captured in T and held to RD.
  - rsp_hit = 1 and the pending bit ends 0 (new entry consumed).
  - Adds a 50-bit bypass register plus a flag.
- Undefined:
  - Response uses old memory data, with hit = pending bit before T.
  - Pending bit ends 1, so the new entry remains for a later fetch.

Test Plan:
- Reset then snoop write id 3 = 50'h2_0000_0000_0ABC; request id 3 -> rsp at T+2 with hit = 1, data = 50'h2_0000_0000_0ABC, acc_id = 3; pending_mask bit 3 returns to 0.
- Request id 5 never written -> hit = 0, data = 0, mem_rd_en pulses once at addr 5.
- Hold rsp_ready = 0 for 4 cycles -> rsp_* stable and req_ready = 0 throughout; handshake, then req_ready = 1 next cycle.
- Same-cycle snoop id 7 = 50'h155 with request id 7, memory holding 50'h0AA and bit 7 pending:
  - Bypass on -> data = 50'h155, mask[7] = 0.
  - Bypass off -> data = 50'h0AA, mask[7] = 1.
- MAX_ACCS = 12, request id 13 -> no mem_rd_en, hit = 0, data = 0.
- Assert rst in RD state -> rsp_valid = 0, pending_mask = 0 immediately; first request after release behaves as in the first scenario.

Source files
------------

// File: rtl/scheduler_sched_info_fetch.sv
`default_nettype none
// ============================================================================
// Module   : scheduler_sched_info_fetch
// Brief    : Fetches per-accelerator schedule-info entries from a 1-cycle
//            registered memory. It tracks unconsumed entries by snooping the
//            memory write port and returns the entry with a hit/miss flag.
//            Optional macro SCHED_INFO_FETCH_BYPASS_EN forwards a same-cycle
//            snoop write to the response.
// Revision : 1.0 - initial release
// ============================================================================
module scheduler_sched_info_fetch #(
    parameter int MAX_ACCS = 16,
    localparam int AW = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_acc_id,
    input  logic                snoop_wr_en,
    input  logic [AW-1:0]       snoop_wr_addr,
    input  logic [49:0]         snoop_wr_din,
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_rd_addr,
    input  logic [49:0]         mem_rd_dout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [AW-1:0]       rsp_acc_id,
    output logic                rsp_hit,
    output logic [49:0]         rsp_data,
    output logic [MAX_ACCS-1:0] pending_mask
);

    localparam logic [AW:0] c_max_accs = (AW+1)'(MAX_ACCS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [MAX_ACCS-1:0]   r_pending;
    logic [AW-1:0]         r_id;
    logic                  r_hit;
    logic                  r_rsp_valid;
    logic [AW-1:0]         r_rsp_acc_id;
    logic                  r_rsp_hit;
    logic [49:0]           r_rsp_data;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_pend_bit;
    logic                  w_hit;
    logic [49:0]           w_rd_data;
    logic [MAX_ACCS-1:0]   w_req_dec;
    logic [MAX_ACCS-1:0]   w_snp_dec;
    logic [MAX_ACCS-1:0]   w_set;
    logic [MAX_ACCS-1:0]   w_clr;
    logic [MAX_ACCS-1:0]   w_mask_nxt;

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = {1'b0, req_acc_id} < c_max_accs;

    // One-hot decodes; out-of-range ids decode to all zeros.
    always_comb begin
        w_req_dec = '0;
        w_snp_dec = '0;
        for (int i = 0; i < MAX_ACCS; i++) begin
            w_req_dec[i] = (req_acc_id == AW'(i));
            w_snp_dec[i] = (snoop_wr_addr == AW'(i));
        end
    end

    assign w_pend_bit = w_in_range && |(w_req_dec & r_pending);
    assign w_set      = snoop_wr_en ? w_snp_dec : '0;
    assign w_clr      = (w_accept && w_hit) ? w_req_dec : '0;

`ifdef SCHED_INFO_FETCH_BYPASS_EN
    logic        w_same;
    logic        r_byp;
    logic [49:0] r_byp_data;

    assign w_same     = snoop_wr_en && (snoop_wr_addr == req_acc_id) && w_in_range;
    assign w_hit      = w_pend_bit || w_same;
    // The fetch consumes the entry being written in the same cycle.
    assign w_mask_nxt = (r_pending | w_set) & ~w_clr;
    assign w_rd_data  = r_byp ? r_byp_data : mem_rd_dout;
`else
    logic w_unused_din;

    assign w_unused_din = ^snoop_wr_din;
    assign w_hit        = w_pend_bit;
    // A same-cycle write survives the fetch and stays pending.
    assign w_mask_nxt   = (r_pending & ~w_clr) | w_set;
    assign w_rd_data    = mem_rd_dout;
`endif

    assign mem_rd_en    = w_accept && w_in_range;
    assign mem_rd_addr  = mem_rd_en ? req_acc_id : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_id         <= '0;
            r_hit        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_acc_id <= '0;
            r_rsp_hit    <= 1'b0;
            r_rsp_data   <= '0;
`ifdef SCHED_INFO_FETCH_BYPASS_EN
            r_byp        <= 1'b0;
            r_byp_data   <= '0;
`endif
        end else begin
            r_pending <= w_mask_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= req_acc_id;
                        r_hit   <= w_hit;
`ifdef SCHED_INFO_FETCH_BYPASS_EN
                        r_byp      <= w_same;
                        r_byp_data <= snoop_wr_din;
`endif
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_rsp_data   <= r_hit ? w_rd_data : '0;
                    r_rsp_acc_id <= r_id;
                    r_rsp_hit    <= r_hit;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_acc_id   = r_rsp_acc_id;
    assign rsp_hit      = r_rsp_hit;
    assign rsp_data     = r_rsp_data;
    assign pending_mask = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_scheduler_sched_info_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_scheduler_sched_info_fetch
// Brief    : Scoreboard bench for scheduler_sched_info_fetch with a read-first
//            memory model and an array-based reference of pending entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scheduler_sched_info_fetch;

    localparam int MAX_ACCS = 12;
    localparam int AW       = 4;
    localparam int DW       = 50;

    typedef struct {
        logic [AW-1:0] id;
        logic          hit;
        logic [DW-1:0] data;
        int            cyc;
        int            stall;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [AW-1:0]       req_acc_id = '0;
    logic                snoop_wr_en = 1'b0;
    logic [AW-1:0]       snoop_wr_addr = '0;
    logic [DW-1:0]       snoop_wr_din = '0;
    logic                mem_rd_en;
    logic [AW-1:0]       mem_rd_addr;
    logic [DW-1:0]       mem_rd_dout = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [AW-1:0]       rsp_acc_id;
    logic                rsp_hit;
    logic [DW-1:0]       rsp_data;
    logic [MAX_ACCS-1:0] pending_mask;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rd_check_next = 0;

    logic [DW-1:0] mem     [MAX_ACCS];
    logic [DW-1:0] ref_mem [MAX_ACCS];
    bit            ref_pend[MAX_ACCS];
    exp_t          exp_q[$];

    scheduler_sched_info_fetch #(.MAX_ACCS(MAX_ACCS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_acc_id   (req_acc_id),
        .snoop_wr_en  (snoop_wr_en),
        .snoop_wr_addr(snoop_wr_addr),
        .snoop_wr_din (snoop_wr_din),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_dout  (mem_rd_dout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_acc_id   (rsp_acc_id),
        .rsp_hit      (rsp_hit),
        .rsp_data     (rsp_data),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Read-first memory: the read captures the old word when written in the same edge.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_dout <= (int'(mem_rd_addr) < MAX_ACCS) ? mem[mem_rd_addr] : 50'h3_dead_beef_0bad;
        if (snoop_wr_en && int'(snoop_wr_addr) < MAX_ACCS)
            mem[snoop_wr_addr] <= snoop_wr_din;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mask();
        logic [63:0] m = '0;
        for (int i = 0; i < MAX_ACCS; i++) m[i] = ref_pend[i];
        return m;
    endfunction

    function automatic logic [DW-1:0] rand50();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic model_snoop(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (int'(a) < MAX_ACCS) begin
            ref_mem[a]  = d;
            ref_pend[a] = 1'b1;
        end
    endtask

    task automatic drive_snoop(input logic [AW-1:0] a, input logic [DW-1:0] d);
        snoop_wr_en   = 1'b1;
        snoop_wr_addr = a;
        snoop_wr_din  = d;
    endtask

    task automatic step();
        @(negedge clk);
        chk("pending_mask", 64'(pending_mask), ref_mask());
        if (rd_check_next) begin
            chk("mem_rd_en_after_accept", 64'(mem_rd_en), 64'(0));
            rd_check_next = 0;
        end
        req_valid   = 1'b0;
        snoop_wr_en = 1'b0;
    endtask

    task automatic snoop_only(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step();
        drive_snoop(a, d);
        model_snoop(a, d);
    endtask

    // Wait for an idle slot (optionally snooping meanwhile), then issue one fetch.
    task automatic wait_ready(input bit bg, output bit ok);
        int waited = 0;
        ok = 1;
        step();
        while (!req_ready) begin
            if (waited++ > 60) begin
                chk("req_ready_timeout", 64'(0), 64'(1));
                ok = 0;
                return;
            end
            if (bg && $urandom_range(0, 2) == 0) begin
                logic [AW-1:0] a = AW'($urandom_range(0, 15));
                logic [DW-1:0] d = rand50();
                drive_snoop(a, d);
                model_snoop(a, d);
            end
            step();
        end
    endtask

    task automatic fetch(input logic [AW-1:0] id, input bit same, input logic [DW-1:0] sd,
                         input int stall, input bit bg);
        bit ok, in_r, s_en, collide, hit;
        logic [AW-1:0] sa;
        logic [DW-1:0] sdat, data;
        exp_t e;
        wait_ready(bg, ok);
        if (!ok) return;
        s_en = same || (bg && $urandom_range(0, 3) == 0);
        sa   = same ? id : AW'($urandom_range(0, 15));
        sdat = same ? sd : rand50();
        req_valid  = 1'b1;
        req_acc_id = id;
        if (s_en) drive_snoop(sa, sdat);
        in_r    = int'(id) < MAX_ACCS;
        collide = s_en && (sa == id) && in_r;
`ifdef SCHED_INFO_FETCH_BYPASS_EN
        hit  = in_r && (ref_pend[id] || collide);
        data = !hit ? '0 : (collide ? sdat : ref_mem[id]);
        if (s_en) model_snoop(sa, sdat);
        if (hit) ref_pend[id] = 1'b0;
`else
        hit  = in_r && ref_pend[id];
        data = hit ? ref_mem[id] : '0;
        if (hit) ref_pend[id] = 1'b0;
        if (s_en) model_snoop(sa, sdat);
`endif
        e = '{id: id, hit: hit, data: data, cyc: cyc + 2, stall: stall};
        exp_q.push_back(e);
        #1;
        chk("mem_rd_en", 64'(mem_rd_en), 64'(in_r));
        if (in_r) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(id));
        rd_check_next = 1;
    endtask

    // Monitor: pops the expected response when rsp_valid rises and checks stability.
    exp_t          mon_e;
    bit            in_rsp  = 0;
    bit            hs_prev = 0;
    int            stall_left = 0;
    logic [AW-1:0] hold_id;
    logic          hold_hit;
    logic [DW-1:0] hold_data;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_rsp    = 0;
            hs_prev   = 0;
            rsp_ready = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("rsp_valid_after_hs", 64'(rsp_valid), 64'(0));
                chk("req_ready_after_hs", 64'(req_ready), 64'(1));
            end
            hs_prev = 0;
            if (rsp_valid) begin
                chk("req_ready_busy", 64'(req_ready), 64'(0));
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(1), 64'(0));
                        stall_left = 0;
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_acc_id", 64'(rsp_acc_id), 64'(mon_e.id));
                        chk("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
                        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                        chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
                        stall_left = mon_e.stall;
                    end
                    in_rsp    = 1;
                    hold_id   = rsp_acc_id;
                    hold_hit  = rsp_hit;
                    hold_data = rsp_data;
                end else begin
                    chk("rsp_stable_id", 64'(rsp_acc_id), 64'(hold_id));
                    chk("rsp_stable_hit", 64'(rsp_hit), 64'(hold_hit));
                    chk("rsp_stable_data", 64'(rsp_data), 64'(hold_data));
                end
                if (stall_left > 0) begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready = 1'b1;
                    hs_prev   = 1;
                    in_rsp    = 0;
                end
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic reset_in_rd();
        bit ok;
        wait_ready(0, ok);
        if (!ok) return;
        req_valid  = 1'b1;
        req_acc_id = 4'd2;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_pending_mask", 64'(pending_mask), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        for (int i = 0; i < MAX_ACCS; i++) ref_pend[i] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MAX_ACCS; i++) begin
            mem[i]      = '0;
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
        end
        req_valid  = 1'b1;
        req_acc_id = 4'd1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_mem_rd_en", 64'(mem_rd_en), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_pending", 64'(pending_mask), 64'(0));
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("release_req_ready", 64'(req_ready), 64'(1));

        snoop_only(4'd3, 50'h2_0000_0000_0ABC);
        fetch(4'd3, 0, '0, 0, 0);
        fetch(4'd5, 0, '0, 0, 0);
        snoop_only(4'd9, 50'h1_2345_6789_ABCD);
        fetch(4'd9, 0, '0, 4, 0);
        snoop_only(4'd7, 50'h0AA);
        fetch(4'd7, 1, 50'h155, 0, 0);
        fetch(4'd7, 0, '0, 0, 0);
        fetch(4'd13, 0, '0, 1, 0);
        fetch(4'd12, 1, 50'h777, 0, 0);
        snoop_only(4'd1, 50'h11);
        snoop_only(4'd2, 50'h22);
        snoop_only(4'd11, 50'h3_FFFF_FFFF_FFFF);
        reset_in_rd();
        snoop_only(4'd3, 50'h2_0000_0000_0ABC);
        fetch(4'd3, 0, '0, 0, 0);
        fetch(4'd11, 0, '0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0)
                snoop_only(AW'($urandom_range(0, 15)), rand50());
            else
                fetch(AW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, rand50(),
                      int'($urandom_range(0, 3)), 1);
        end

        for (int w = 0; w < 100 && (exp_q.size() != 0 || rsp_valid); w++) step();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
